// File: rtl/l1c_mem_arb_pkg.sv
// Shared cache definitions: bus widths, line geometry and the
// arbiter's state and owner encodings.
package l1c_mem_arb_pkg;
    localparam int DATA_BITS       = 32;
    localparam int CACHE_LINE_BITS = 128;
    localparam int BEATS_DEF       = CACHE_LINE_BITS / DATA_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic logic [1:0] owner_onehot(owner_t o);
        return (o == OWN_D) ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/l1c_mem_arb_rr_arb2.sv
// Two-way round-robin pick: on a tie, the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,   // 1 = requester 1 was served last
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/l1c_mem_arb.sv
// Shares the single CPU-wrapper master port between the I-cache (line reads)
// and the D-cache (line reads or single-word writes).
module l1c_mem_arb
    import l1c_mem_arb_pkg::*;
#(
    parameter int BEATS = BEATS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [1:0]  m_len,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    input  logic        m_rready,
    input  logic        m_bdone,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,
    output logic [1:0]  grant
);
    localparam int             CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
    localparam logic [1:0]     RD_LEN    = 2'(BEATS - 1);

    arb_state_t    state, state_nx;
    owner_t        owner, last_owner;
    logic [CW-1:0] beat_cnt;
    logic [1:0]    gnt;
    logic          beat, rd_last, wr_done;
    logic          sel_write;
    logic [31:0]   sel_addr;

    rr_arb2 u_rr (
        .req  ({d_req, i_req}),
        .last (last_owner == OWN_D),
        .gnt  (gnt)
    );

    assign beat    = (state == RD_BURST) & m_rvalid & m_rready;
    assign rd_last = beat & (beat_cnt == LAST_BEAT);
    assign wr_done = (state == WR_WAIT) & m_bdone;

    // Only the D-cache can write; an I-cache grant is always a line read.
    assign sel_write = gnt[1] & d_write;
    assign sel_addr  = gnt[1] ? d_addr : i_addr;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (gnt[1])      state_nx = d_write ? WR_WAIT : RD_BURST;
                      else if (gnt[0]) state_nx = RD_BURST;
            RD_BURST: if (rd_last)     state_nx = IDLE;
            WR_WAIT:  if (m_bdone)     state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_D;
            beat_cnt   <= '0;
            m_addr     <= '0;
            m_write    <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= 4'hF;
            m_len      <= '0;
        end else begin
            state <= state_nx;
            // Request inputs are sampled only here; the transaction runs on latched copies.
            if (state == IDLE && gnt != 2'b00) begin
                owner   <= gnt[1] ? OWN_D : OWN_I;
                m_write <= sel_write;
                m_addr  <= sel_write ? sel_addr : {sel_addr[31:4], 4'h0};
                m_len   <= sel_write ? 2'd0 : RD_LEN;
                m_wdata <= sel_write ? d_wdata : 32'h0;
                m_wstrb <= sel_write ? d_wstrb : 4'hF;
            end
            if (beat)
                beat_cnt <= rd_last ? '0 : beat_cnt + 1'b1;
            if (rd_last || wr_done)
                last_owner <= owner;
        end
    end

    assign m_req = (state != IDLE);
    assign grant = m_req ? owner_onehot(owner) : 2'b00;

    assign i_rvalid = beat & (owner == OWN_I);
    assign d_rvalid = beat & (owner == OWN_D);
    assign i_rdata  = (state == RD_BURST && owner == OWN_I) ? m_rdata : 32'h0;
    assign d_rdata  = (state == RD_BURST && owner == OWN_D) ? m_rdata : 32'h0;
    assign i_done   = rd_last & (owner == OWN_I);
    assign d_done   = (rd_last & (owner == OWN_D)) | wr_done;
endmodule

// File: tb/tb_l1c_mem_arb.sv
// Directed table, hand sequences for the multi-cycle corners, and a randomized
// run against a transaction-level model of the arbiter.
module tb_l1c_mem_arb;
    localparam int BEATS = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 0, d_req = 0, d_write = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_wstrb = 4'hF;
    logic        m_req, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_len, grant;
    logic [31:0] m_rdata = 0;
    logic        m_rvalid = 0, m_rready = 0, m_bdone = 0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;

    int ntest = 0, nfail = 0;

    l1c_mem_arb #(.BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_req(m_req), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_len(m_len),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_bdone(m_bdone),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rbase;
        logic [31:0] exp_addr;
        logic [1:0]  exp_len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed BEATS back-to-back handshaked beats to the current read owner.
    task automatic do_beats(input logic is_d, input logic [31:0] base);
        for (int b = 0; b < BEATS; b++) begin
            m_rvalid = 1; m_rready = 1; m_rdata = base + b;
            #1;
            chk("own_rvalid", is_d ? d_rvalid : i_rvalid, 1);
            chk("own_rdata",  is_d ? d_rdata  : i_rdata,  base + b);
            chk("own_done",   is_d ? d_done   : i_done,   (b == BEATS - 1));
            chk("other_rvalid", is_d ? i_rvalid : d_rvalid, 0);
            chk("other_rdata",  is_d ? i_rdata  : d_rdata,  0);
            tick();
        end
        m_rvalid = 0; m_rready = 0;
    endtask

    task automatic run_vec(input vec_t v);
        i_req = !v.is_d; i_addr = v.addr;
        d_req = v.is_d;  d_addr = v.addr; d_write = v.wr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        tick();
        i_req = 0; d_req = 0; d_addr = 32'h0BAD_0000; d_wdata = 32'h0; d_wstrb = 4'h0;
        chk("vec_m_req",   m_req,   1);
        chk("vec_grant",   grant,   v.is_d ? 2'b10 : 2'b01);
        chk("vec_m_addr",  m_addr,  v.exp_addr);
        chk("vec_m_len",   m_len,   v.exp_len);
        chk("vec_m_write", m_write, v.wr);
        chk("vec_m_wstrb", m_wstrb, v.wr ? v.wstrb : 4'hF);
        if (v.wr) begin
            chk("vec_m_wdata", m_wdata, v.wdata);
            for (int k = 0; k < 3; k++) begin
                m_rvalid = 1; m_rready = 1;
                #1;
                chk("wr_early_done", d_done, 0);
                chk("wr_no_rvalid", {i_rvalid, d_rvalid, i_done}, 0);
                tick();
            end
            m_rvalid = 0; m_rready = 0; m_bdone = 1;
            #1;
            chk("wr_d_done", d_done, 1);
            chk("wr_i_quiet", {i_rvalid, i_done, d_rvalid}, 0);
            tick();
            m_bdone = 0;
        end else begin
            do_beats(v.is_d, v.rbase);
        end
        chk("vec_idle_m_req", m_req, 0);
        chk("vec_idle_grant", grant, 0);
    endtask

    // Transaction-level reference model for the random phase.
    logic        mb, mw, mown, mlast;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mwstrb;
    int          hs;

    task automatic model_step();
        logic beat, done;
        if (!mb) begin
            chk("rnd_idle_m_req", m_req, 0);
            chk("rnd_idle_grant", grant, 0);
            chk("rnd_idle_outs", {i_rvalid, i_done, d_rvalid, d_done}, 0);
            if (i_req || d_req) begin
                mown   = (i_req && d_req) ? !mlast : d_req;
                mb     = 1;
                mw     = mown && d_write;
                maddr  = mown ? d_addr : i_addr;
                mwdata = d_wdata;
                mwstrb = d_wstrb;
                hs     = 0;
            end
        end else begin
            beat = !mw && m_rvalid && m_rready;
            done = mw ? m_bdone : (beat && hs == BEATS - 1);
            chk("rnd_m_req",   m_req,   1);
            chk("rnd_grant",   grant,   mown ? 2'b10 : 2'b01);
            chk("rnd_m_addr",  m_addr,  mw ? maddr : (maddr & 32'hFFFF_FFF0));
            chk("rnd_m_len",   m_len,   mw ? 2'd0 : 2'(BEATS - 1));
            chk("rnd_m_write", m_write, mw);
            chk("rnd_m_wstrb", m_wstrb, mw ? mwstrb : 4'hF);
            if (mw) chk("rnd_m_wdata", m_wdata, mwdata);
            chk("rnd_i_rvalid", i_rvalid, beat && !mown);
            chk("rnd_d_rvalid", d_rvalid, beat && mown);
            chk("rnd_i_rdata",  i_rdata, (!mw && !mown) ? m_rdata : 32'h0);
            chk("rnd_d_rdata",  d_rdata, (!mw && mown)  ? m_rdata : 32'h0);
            chk("rnd_i_done",   i_done, done && !mown);
            chk("rnd_d_done",   d_done, done && mown);
            if (beat) hs++;
            if (done) begin
                mb = 0;
                mlast = mown;
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h0000_1234, 32'h0,         4'hF,    32'h0000_00A0, 32'h0000_1230, 2'd3};
        vecs[1] = '{1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1100, 32'h0,         32'h8000_0004, 2'd0};
        vecs[2] = '{1, 0, 32'hFFFF_FFFF, 32'h1111_1111, 4'h0,    32'h5000_0000, 32'hFFFF_FFF0, 2'd3};
        vecs[3] = '{0, 0, 32'h0000_000F, 32'h0,         4'hF,    32'h0000_0C00, 32'h0000_0000, 2'd3};
        vecs[4] = '{1, 1, 32'h0000_0003, 32'h1234_5678, 4'b0000, 32'h0,         32'h0000_0003, 2'd0};

        // Reset values, with requests already pending.
        i_req = 1; d_req = 1; i_addr = 32'hFFFF_FFFF; m_rvalid = 1; m_rready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_misc", {m_write, m_wstrb, m_len}, {1'b0, 4'hF, 2'd0});
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_outs", {i_rvalid, i_done, d_rvalid, d_done}, 0);
        i_req = 0; d_req = 0; m_rvalid = 0; m_rready = 0;
        rst = 0;
        tick();

        // Tie out of reset: I first, one idle cycle, then D, then I again.
        i_req = 1; i_addr = 32'h0000_1234; d_req = 1; d_addr = 32'h0000_2008; d_write = 0;
        tick();
        chk("tie_first_i", grant, 2'b01);
        do_beats(0, 32'h0000_0100);
        chk("tie_gap_m_req", m_req, 0);
        tick();
        chk("tie_then_d", grant, 2'b10);
        chk("tie_d_addr", m_addr, 32'h0000_2000);
        do_beats(1, 32'h0000_0200);
        chk("tie_gap2_m_req", m_req, 0);
        tick();
        chk("tie_back_to_i", grant, 2'b01);
        i_req = 0; d_req = 0;
        do_beats(0, 32'h0000_0300);

        for (int n = 0; n < 5; n++) run_vec(vecs[n]);

        // Stalled handshakes: only m_rvalid & m_rready beats count.
        i_req = 1; i_addr = 32'h0000_4440;
        tick();
        i_req = 0;
        for (int c = 0; c < 7; c++) begin
            m_rvalid = 1; m_rready = (c % 2 == 0); m_rdata = 32'h0000_0E00 + c;
            #1;
            chk("stall_rvalid", i_rvalid, m_rready);
            chk("stall_done", i_done, (c == 6));
            tick();
        end
        m_rvalid = 0; m_rready = 0;
        chk("stall_idle", m_req, 0);

        // Reset after beat 2 aborts without a done pulse; next read restarts at beat 0.
        i_req = 1; i_addr = 32'h0000_7770;
        tick();
        i_req = 0;
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1; m_rready = 1; m_rdata = b;
            tick();
        end
        rst = 1;
        #1;
        chk("abort_m_req", m_req, 0);
        chk("abort_grant", grant, 0);
        chk("abort_m_addr", m_addr, 0);
        chk("abort_m_misc", {m_write, m_wstrb, m_len}, {1'b0, 4'hF, 2'd0});
        chk("abort_no_done", {i_rvalid, i_done, d_rvalid, d_done}, 0);
        m_rvalid = 0; m_rready = 0;
        tick();
        rst = 0;
        tick();
        run_vec(vecs[0]);

        // Randomized run against the model, starting from a fresh reset.
        rst = 1;
        tick();
        rst = 0;
        mb = 0; mw = 0; mown = 0; mlast = 1; hs = 0; maddr = 0; mwdata = 0; mwstrb = 4'hF;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_req    = ($urandom_range(0, 1) == 1);
            i_addr   = $urandom;
            d_req    = ($urandom_range(0, 1) == 1);
            d_addr   = $urandom;
            d_write  = ($urandom_range(0, 1) == 1);
            d_wdata  = $urandom;
            d_wstrb  = 4'($urandom);
            m_rdata  = $urandom;
            m_rvalid = ($urandom_range(0, 1) == 1);
            m_rready = ($urandom_range(0, 3) != 0);
            m_bdone  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
